scoreboard_buffer: RTL and testbench
====================================

// Module: scoreboard_buffer
// PURPOSE
//  Parametrised in-order issue / out-of-order writeback / in-order commit scoreboard.
//  Sits between issue and commit stages. Allocates a transaction ID per issued instruction,
//  collects results from NR_WB_PORTS functional units, and presents the oldest entry to commit.
//  Generalises the fixed 4-entry / 3-port scoreboard to arbitrary depth and port count.
// PARAMETERS
//  NR_ENTRIES    4   entry count; power of two, >= 2
//  NR_WB_PORTS   3   writeback ports, >= 1
//  XLEN          64  result / PC width
//  TID_W         $clog2(NR_ENTRIES)  trans_id width (localparam, derived)
// PORTS
//  clk_i            in   1                  clock
//  rst_ni           in   1                  synchronous reset, active low
//  flush_i          in   1                  discard all entries
//  issue_valid_i    in   1                  issue request
//  issue_ready_o    out  1                  entry free (not full)
//  issue_rd_i       in   5                  destination register
//  issue_pc_i       in   XLEN               instruction PC
//  issue_tid_o      out  TID_W              trans_id allocated to current issue
//  wb_valid_i       in   NR_WB_PORTS        per-port writeback strobe
//  wb_tid_i         in   NR_WB_PORTS*TID_W  per-port trans_id
//  wb_data_i        in   NR_WB_PORTS*XLEN   per-port result
//  wb_ex_i          in   NR_WB_PORTS        per-port exception flag
//  commit_valid_o   out  1                  head entry issued and written back
//  commit_rd_o      out  5                  head rd
//  commit_data_o    out  XLEN               head result
//  commit_pc_o      out  XLEN               head PC
//  commit_ex_o      out  1                  head raised exception
//  commit_ack_i     in   1                  pop head; legal only while commit_valid_o
//  rd_busy_o        out  32                 bit r set if any live entry targets rd r (bit 0 always 0)
// BEHAVIOUR
//  - One clock clk_i; rst_ni synchronous active-low. Reset: pointers/count 0, all entry valid/done
//    bits 0; issue_ready_o=1, issue_tid_o=0, commit_valid_o=0, rd_busy_o=0, data outputs 0.
//  - Circular buffer, issue_ptr / commit_ptr of TID_W bits, wrap modulo NR_ENTRIES; count TID_W+1 bits.
//  - issue_ready_o = (count != NR_ENTRIES); no same-cycle pass-through when full, even with commit_ack_i.
//  - Issue fires on issue_valid_i && issue_ready_o: entry[issue_ptr] <= {live=1,done=0,ex=0,rd,pc};
//    issue_tid_o = issue_ptr (combinational); issue_ptr++ next cycle.
//  - Writeback: for each port p with wb_valid_i[p] and entry[wb_tid_i[p]].live && !done:
//    done<=1, data<=wb_data_i[p], ex<=wb_ex_i[p]. Writeback to non-live/already-done entry ignored.
//    Two ports same tid same cycle: lowest port index wins.
//  - Commit outputs combinational from entry[commit_ptr]; commit_valid_o = live && done.
//    Writeback-to-commit latency 1 cycle (no wb->commit bypass). Issue-to-commit min 2 cycles.
//  - commit_ack_i: entry[commit_ptr].live<=0, commit_ptr++. Ack without commit_valid_o ignored.
//  - Simultaneous issue + commit: count unchanged. Issue into slot being freed impossible (ready=0 when full).
//  - flush_i: same effect as reset next cycle; priority over issue, writeback and commit same cycle.
//  - rd_busy_o: OR over live entries of onehot(rd), rd=0 masked; combinational from state.
// CONFIGURATION
//  SB_FORWARD_EN defined: adds ports fwd_rs_i[4:0] in, fwd_hit_o out, fwd_data_o[XLEN] out.
//   Search live&&done entries with rd==fwd_rs_i (rs!=0); youngest match relative to commit_ptr
//   wins; hit=1 and data=its result; no match or youngest match not done -> hit=0, data=0.
//  SB_FORWARD_EN undefined: ports absent, no search logic; rd_busy_o only.
// TESTING
//  1. Reset, then issue rd=5 pc=0x80 -> issue_tid_o=0, rd_busy_o[5]=1; wb tid0 data=0xAB next cycle ->
//     following cycle commit_valid_o=1, commit_data_o=0xAB, commit_pc_o=0x80; ack -> rd_busy_o=0.
//  2. Issue NR_ENTRIES instrs -> issue_ready_o=0; issue_valid_i held + commit_ack_i -> no issue that
//     cycle, ready=1 next; further issues get tid wrapping 0,1,... .
//  3. Out-of-order wb: issue tids 0,1,2; wb tid2 then tid1 -> commit_valid_o stays 0 until tid0 written.
//  4. Ports 0 and 1 both write tid1 (data 0x11/0x22) -> committed data 0x11; repeat wb to tid1 -> ignored.
//  5. flush_i with 3 live entries plus concurrent issue & wb -> next cycle count 0, issue_tid_o=0, ready=1.
//  6. SB_FORWARD_EN: tids 0,1 both rd=7, done with 0x1/0x2; fwd_rs_i=7 -> fwd_hit_o=1, fwd_data_o=0x2.

Source files
------------

// File: rtl/scoreboard_buffer.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard.
// Optional feature macro: SB_FORWARD_EN (result forwarding search by rs).
module scoreboard_buffer #(
   parameter int  NR_ENTRIES  = 4,
   parameter int  NR_WB_PORTS = 3,
   parameter int  XLEN        = 64,
   localparam int TID_W       = $clog2(NR_ENTRIES)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  logic [4:0]                   issue_rd_i,
   input  logic [XLEN-1:0]              issue_pc_i,
   output logic [TID_W-1:0]             issue_tid_o,
   input  logic [NR_WB_PORTS-1:0]       wb_valid_i,
   input  logic [NR_WB_PORTS*TID_W-1:0] wb_tid_i,
   input  logic [NR_WB_PORTS*XLEN-1:0]  wb_data_i,
   input  logic [NR_WB_PORTS-1:0]       wb_ex_i,
   output logic                         commit_valid_o,
   output logic [4:0]                   commit_rd_o,
   output logic [XLEN-1:0]              commit_data_o,
   output logic [XLEN-1:0]              commit_pc_o,
   output logic                         commit_ex_o,
   input  logic                         commit_ack_i,
`ifdef SB_FORWARD_EN
   input  logic [4:0]                   fwd_rs_i,
   output logic                         fwd_hit_o,
   output logic [XLEN-1:0]              fwd_data_o,
`endif
   output logic [31:0]                  rd_busy_o
);

   logic [NR_ENTRIES-1:0] r_live;
   logic [NR_ENTRIES-1:0] r_done;
   logic [NR_ENTRIES-1:0] r_ex;
   logic [4:0]            r_rd   [NR_ENTRIES];
   logic [XLEN-1:0]       r_pc   [NR_ENTRIES];
   logic [XLEN-1:0]       r_data [NR_ENTRIES];
   logic [TID_W-1:0]      r_issue_ptr;
   logic [TID_W-1:0]      r_commit_ptr;
   logic [TID_W:0]        r_count;

   logic                  w_issue_fire;
   logic                  w_commit_fire;
   logic [NR_ENTRIES-1:0] w_wb_hit;
   logic [NR_ENTRIES-1:0] w_wb_ex;
   logic [XLEN-1:0]       w_wb_data [NR_ENTRIES];

   assign issue_ready_o  = (r_count != (TID_W+1)'(NR_ENTRIES));
   assign issue_tid_o    = r_issue_ptr;
   assign w_issue_fire   = issue_valid_i && issue_ready_o;

   assign commit_valid_o = r_live[r_commit_ptr] && r_done[r_commit_ptr];
   assign commit_rd_o    = r_rd[r_commit_ptr];
   assign commit_data_o  = r_data[r_commit_ptr];
   assign commit_pc_o    = r_pc[r_commit_ptr];
   assign commit_ex_o    = r_ex[r_commit_ptr];
   assign w_commit_fire  = commit_ack_i && commit_valid_o;

   // Ports scanned high to low so the lowest index overwrites last.
   always_comb begin
      w_wb_hit = '0;
      w_wb_ex  = '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
         w_wb_data[e] = '0;
      end
      for (int p = NR_WB_PORTS-1; p >= 0; p--) begin
         if (wb_valid_i[p]) begin
            w_wb_hit[wb_tid_i[p*TID_W +: TID_W]]  = 1'b1;
            w_wb_ex[wb_tid_i[p*TID_W +: TID_W]]   = wb_ex_i[p];
            w_wb_data[wb_tid_i[p*TID_W +: TID_W]] = wb_data_i[p*XLEN +: XLEN];
         end
      end
      w_wb_hit = w_wb_hit & r_live & ~r_done;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_live       <= '0;
         r_done       <= '0;
         r_ex         <= '0;
         r_issue_ptr  <= '0;
         r_commit_ptr <= '0;
         r_count      <= '0;
         for (int e = 0; e < NR_ENTRIES; e++) begin
            r_rd[e]   <= '0;
            r_pc[e]   <= '0;
            r_data[e] <= '0;
         end
      end else begin
         for (int e = 0; e < NR_ENTRIES; e++) begin
            if (w_wb_hit[e]) begin
               r_done[e] <= 1'b1;
               r_ex[e]   <= w_wb_ex[e];
               r_data[e] <= w_wb_data[e];
            end
         end
         if (w_commit_fire) begin
            r_live[r_commit_ptr] <= 1'b0;
            r_commit_ptr         <= r_commit_ptr + TID_W'(1);
         end
         if (w_issue_fire) begin
            r_live[r_issue_ptr] <= 1'b1;
            r_done[r_issue_ptr] <= 1'b0;
            r_ex[r_issue_ptr]   <= 1'b0;
            r_rd[r_issue_ptr]   <= issue_rd_i;
            r_pc[r_issue_ptr]   <= issue_pc_i;
            r_issue_ptr         <= r_issue_ptr + TID_W'(1);
         end
         unique case ({w_issue_fire, w_commit_fire})
            2'b10:   r_count <= r_count + (TID_W+1)'(1);
            2'b01:   r_count <= r_count - (TID_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      rd_busy_o = '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
         if (r_live[e]) begin
            rd_busy_o[r_rd[e]] = 1'b1;
         end
      end
      rd_busy_o[0] = 1'b0;
   end

`ifdef SB_FORWARD_EN
   logic [TID_W-1:0] w_fidx;

   // Walk oldest to youngest; the last live match is the youngest producer.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      w_fidx     = '0;
      for (int k = 0; k < NR_ENTRIES; k++) begin
         w_fidx = r_commit_ptr + TID_W'(k);
         if (r_live[w_fidx] && (r_rd[w_fidx] == fwd_rs_i) && (fwd_rs_i != 5'd0)) begin
            fwd_hit_o  = r_done[w_fidx];
            fwd_data_o = r_done[w_fidx] ? r_data[w_fidx] : '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_scoreboard_buffer.sv
// Self-checking bench for scoreboard_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_scoreboard_buffer;

   localparam int N  = 4;
   localparam int NP = 3;
   localparam int XL = 64;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic            iv;
   logic [4:0]      ird;
   logic [XL-1:0]   ipc;
   logic [NP-1:0]   wbv;
   logic [NP*TW-1:0] wbt;
   logic [NP*XL-1:0] wbd;
   logic [NP-1:0]   wbe;
   logic            ack;
   logic [4:0]      fwd_rs;

   logic            o_ready;
   logic [TW-1:0]   o_tid;
   logic            o_cv;
   logic [4:0]      o_crd;
   logic [XL-1:0]   o_cdata;
   logic [XL-1:0]   o_cpc;
   logic            o_cex;
   logic [31:0]     o_busy;
   logic            o_fhit;
   logic [XL-1:0]   o_fdata;

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 0;

   always #5 clk = ~clk;

   scoreboard_buffer #(
      .NR_ENTRIES(N),
      .NR_WB_PORTS(NP),
      .XLEN(XL)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .flush_i(flush),
      .issue_valid_i(iv),
      .issue_ready_o(o_ready),
      .issue_rd_i(ird),
      .issue_pc_i(ipc),
      .issue_tid_o(o_tid),
      .wb_valid_i(wbv),
      .wb_tid_i(wbt),
      .wb_data_i(wbd),
      .wb_ex_i(wbe),
      .commit_valid_o(o_cv),
      .commit_rd_o(o_crd),
      .commit_data_o(o_cdata),
      .commit_pc_o(o_cpc),
      .commit_ex_o(o_cex),
      .commit_ack_i(ack),
`ifdef SB_FORWARD_EN
      .fwd_rs_i(fwd_rs),
      .fwd_hit_o(o_fhit),
      .fwd_data_o(o_fdata),
`endif
      .rd_busy_o(o_busy)
   );

`ifndef SB_FORWARD_EN
   assign o_fhit  = 1'b0;
   assign o_fdata = '0;
`endif

   typedef struct {
      int          tid;
      logic [4:0]  rd;
      logic [63:0] pc;
      bit          done;
      logic [63:0] data;
      bit          ex;
   } ent_t;

   ent_t q[$];
   int   next_tid = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_cv();
      return (q.size() > 0) && q[0].done;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      foreach (q[i]) b[q[i].rd] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   // Reference model: a FIFO of in-flight instructions in program order.
   always @(posedge clk) begin
      if (!rst_n || flush) begin
         q.delete();
         next_tid = 0;
      end else begin
         bit   cv;
         bit   full;
         ent_t e;
         cv   = m_cv();
         full = (q.size() == N);
         for (int p = 0; p < NP; p++) begin
            if (wbv[p]) begin
               foreach (q[i]) begin
                  if (q[i].tid == int'(wbt[p*TW +: TW]) && !q[i].done) begin
                     q[i].done = 1;
                     q[i].data = wbd[p*XL +: XL];
                     q[i].ex   = wbe[p];
                  end
               end
            end
         end
         if (ack && cv) void'(q.pop_front());
         if (iv && !full) begin
            e.tid  = next_tid;
            e.rd   = ird;
            e.pc   = ipc;
            e.done = 0;
            e.data = '0;
            e.ex   = 0;
            q.push_back(e);
            next_tid = (next_tid + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_ready", 64'(o_ready), 64'(q.size() < N));
         chk("m_tid", 64'(o_tid), 64'(next_tid));
         chk("m_cvalid", 64'(o_cv), 64'(m_cv()));
         chk("m_busy", 64'(o_busy), 64'(m_busy()));
         if (m_cv()) begin
            chk("m_crd", 64'(o_crd), 64'(q[0].rd));
            chk("m_cdata", o_cdata, q[0].data);
            chk("m_cpc", o_cpc, q[0].pc);
            chk("m_cex", 64'(o_cex), 64'(q[0].ex));
         end
      end
   end

   task automatic clr();
      flush = 0; iv = 0; ird = '0; ipc = '0;
      wbv = '0; wbt = '0; wbd = '0; wbe = '0;
      ack = 0; fwd_rs = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic issue(logic [4:0] rd, logic [63:0] pc);
      iv = 1; ird = rd; ipc = pc;
   endtask

   task automatic wb(int p, int tid, logic [63:0] d, bit e);
      wbv[p] = 1'b1;
      wbt[p*TW +: TW] = TW'(tid);
      wbd[p*XL +: XL] = d;
      wbe[p] = e;
   endtask

   initial begin
      clr();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      started = 1;

      // reset state
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_tid", 64'(o_tid), 64'd0);
      chk("rst_cvalid", 64'(o_cv), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_cdata", o_cdata, 64'd0);

      // basic issue -> wb -> commit
      issue(5, 64'h80);
      chk("t1_tid", 64'(o_tid), 64'd0);
      step();
      chk("t1_busy", 64'(o_busy), 64'h20);
      chk("t1_cv0", 64'(o_cv), 64'd0);
      wb(0, 0, 64'hAB, 0);
      step();
      chk("t1_cv1", 64'(o_cv), 64'd1);
      chk("t1_data", o_cdata, 64'hAB);
      chk("t1_pc", o_cpc, 64'h80);
      ack = 1;
      step();
      chk("t1_busy0", 64'(o_busy), 64'd0);
      chk("t1_cvx", 64'(o_cv), 64'd0);

      // full buffer, ack with held issue, tid wrap
      flush = 1;
      step();
      issue(1, 64'h100);
      step();
      issue(2, 64'h104);
      wb(0, 0, 64'h50, 0);
      step();
      issue(3, 64'h108);
      step();
      issue(4, 64'h10C);
      step();
      chk("t2_full", 64'(o_ready), 64'd0);
      chk("t2_cv", 64'(o_cv), 64'd1);
      chk("t2_busy", 64'(o_busy), 64'h1E);
      issue(9, 64'h110);
      ack = 1;
      step();
      chk("t2_ready", 64'(o_ready), 64'd1);
      chk("t2_tid0", 64'(o_tid), 64'd0);
      chk("t2_busy2", 64'(o_busy), 64'h1C);
      issue(9, 64'h110);
      step();
      chk("t2_tid1", 64'(o_tid), 64'd1);
      chk("t2_full2", 64'(o_ready), 64'd0);
      chk("t2_busy3", 64'(o_busy), 64'h21C);
      flush = 1;
      step();

      // out-of-order writeback
      issue(10, 64'h200); step();
      issue(11, 64'h204); step();
      issue(12, 64'h208); step();
      wb(1, 2, 64'hC2, 0);
      step();
      chk("t3_cv_a", 64'(o_cv), 64'd0);
      wb(2, 1, 64'hC1, 1);
      step();
      chk("t3_cv_b", 64'(o_cv), 64'd0);
      wb(0, 0, 64'hC0, 0);
      step();
      chk("t3_cv_c", 64'(o_cv), 64'd1);
      chk("t3_d0", o_cdata, 64'hC0);
      ack = 1;
      step();
      chk("t3_d1", o_cdata, 64'hC1);
      chk("t3_ex1", 64'(o_cex), 64'd1);
      chk("t3_rd1", 64'(o_crd), 64'd11);
      ack = 1;
      step();
      chk("t3_d2", o_cdata, 64'hC2);
      chk("t3_ex2", 64'(o_cex), 64'd0);
      ack = 1;
      step();
      chk("t3_empty", 64'(o_busy), 64'd0);

      // same-tid writeback collision and repeat writeback
      flush = 1;
      step();
      issue(20, 64'h300); step();
      issue(21, 64'h304); step();
      wb(0, 1, 64'h11, 0);
      wb(1, 1, 64'h22, 0);
      wb(2, 0, 64'h33, 0);
      step();
      wb(2, 1, 64'h99, 1);
      step();
      chk("t4_d0", o_cdata, 64'h33);
      ack = 1;
      step();
      chk("t4_d1", o_cdata, 64'h11);
      chk("t4_ex1", 64'(o_cex), 64'd0);
      chk("t4_rd1", 64'(o_crd), 64'd21);
      ack = 1;
      step();

      // flush beats concurrent issue / writeback
      issue(1, 64'h400); step();
      issue(2, 64'h404); step();
      issue(3, 64'h408); step();
      chk("t5_busy", 64'(o_busy), 64'hE);
      chk("t5_tid", 64'(o_tid), 64'd1);
      flush = 1;
      issue(4, 64'h40C);
      wb(0, 2, 64'h5, 0);
      ack = 1;
      step();
      chk("t5_ready", 64'(o_ready), 64'd1);
      chk("t5_tid0", 64'(o_tid), 64'd0);
      chk("t5_busy0", 64'(o_busy), 64'd0);
      chk("t5_cv", 64'(o_cv), 64'd0);
      issue(6, 64'h500);
      step();
      ack = 1;
      step();
      chk("t5_ackign", 64'(o_busy), 64'h40);
      chk("t5_tid1", 64'(o_tid), 64'd1);
      wb(0, 0, 64'h66, 0);
      step();
      chk("t5_cv1", 64'(o_cv), 64'd1);
      ack = 1;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 39) == 0) flush = 1;
         if ($urandom_range(0, 2) != 0) issue(5'($urandom_range(0, 31)), {$urandom, $urandom});
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 2) == 0)
               wb(p, $urandom_range(0, N-1), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
         end
         if (m_cv() && $urandom_range(0, 1) == 1) ack = 1;
         step();
      end

`ifdef SB_FORWARD_EN
      flush = 1;
      step();
      issue(7, 64'h600); step();
      issue(7, 64'h604); step();
      wb(0, 0, 64'h1, 0);
      wb(1, 1, 64'h2, 0);
      step();
      fwd_rs = 7;
      #1;
      chk("t6_hit", 64'(o_fhit), 64'd1);
      chk("t6_data", o_fdata, 64'h2);
      issue(7, 64'h608);
      step();
      fwd_rs = 7;
      #1;
      chk("t6_nd_hit", 64'(o_fhit), 64'd0);
      chk("t6_nd_data", o_fdata, 64'd0);
      fwd_rs = 0;
      #1;
      chk("t6_r0_hit", 64'(o_fhit), 64'd0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
